// File: rtl/pc_src_unit.sv
// Next-PC source mux and program-counter register with a trap sequencer.
// Bad writes and external exceptions divert to a fixed vector until acked.
module pc_src_unit #(
   parameter int               WIDTH       = 32,
   parameter int               NSRC        = 6,
   parameter int               SEL_W       = 3,
   parameter int               VEC_SLOT    = 3,
   parameter logic [WIDTH-1:0] VEC_VALUE   = 'h04C4B4B4,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter bit               ALIGN_CHECK = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [SEL_W-1:0]      sel,
   input  logic [NSRC*WIDTH-1:0] data_in,
   input  logic                  pc_write,
   input  logic                  pc_write_cond,
   input  logic                  cond,
   input  logic                  exc_req,
   input  logic                  trap_ack,
   output logic [WIDTH-1:0]      mux_out,
   output logic [WIDTH-1:0]      pc,
   output logic [WIDTH-1:0]      epc,
   output logic [WIDTH-1:0]      bad_value,
   output logic [1:0]            cause,
   output logic                  trap_valid
);

   typedef enum logic {RUN, TRAP} state_t;

   state_t state;
   logic   we;
   logic   sel_bad;
   logic   mis;

   assign we      = pc_write | (pc_write_cond & cond);
   assign sel_bad = (32'(sel) >= NSRC);
   assign mis     = ALIGN_CHECK && (mux_out[1:0] != 2'b00);

   always_comb begin
      mux_out = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (32'(sel) == i)
            mux_out = data_in[i*WIDTH +: WIDTH];
      end
      // The vector slot overrides whatever is wired into its lane.
      if (32'(sel) == VEC_SLOT)
         mux_out = VEC_VALUE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         pc         <= RESET_PC;
         epc        <= '0;
         bad_value  <= '0;
         cause      <= 2'd0;
         trap_valid <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (exc_req) begin
                  pc         <= VEC_VALUE;
                  epc        <= pc;
                  cause      <= 2'd1;
                  trap_valid <= 1'b1;
                  state      <= TRAP;
               end else if (we && sel_bad) begin
                  pc         <= VEC_VALUE;
                  epc        <= pc;
                  bad_value  <= '0;
                  cause      <= 2'd3;
                  trap_valid <= 1'b1;
                  state      <= TRAP;
               end else if (we && mis) begin
                  pc         <= VEC_VALUE;
                  epc        <= pc;
                  bad_value  <= mux_out;
                  cause      <= 2'd2;
                  trap_valid <= 1'b1;
                  state      <= TRAP;
               end else if (we) begin
                  pc <= mux_out;
               end
            end
            TRAP: begin
               // Everything but the ack is dropped while trapped.
               if (trap_ack) begin
                  cause      <= 2'd0;
                  trap_valid <= 1'b0;
                  state      <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_src_unit.sv
// Randomised and directed bench for pc_src_unit.
// Compares every output against a rule-level model each cycle.
module tb_pc_src_unit;

   localparam int          W    = 32;
   localparam int          NS   = 6;
   localparam int          VS   = 3;
   localparam logic [31:0] VEC  = 32'h04C4B4B4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [2:0]    sel = '0;
   logic [NS*W-1:0] data_in;
   logic          pc_write = 1'b0;
   logic          pc_write_cond = 1'b0;
   logic          cond = 1'b0;
   logic          exc_req = 1'b0;
   logic          trap_ack = 1'b0;
   logic [W-1:0]  mux_out;
   logic [W-1:0]  pc;
   logic [W-1:0]  epc;
   logic [W-1:0]  bad_value;
   logic [1:0]    cause;
   logic          trap_valid;

   logic [31:0] lanes [NS];

   logic [31:0] m_pc, m_epc, m_bad;
   int          m_cause;
   bit          m_trap;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   always_comb begin
      data_in = '0;
      for (int i = 0; i < NS; i++)
         data_in[i*W +: W] = lanes[i];
   end

   pc_src_unit dut (
      .clk(clk),
      .reset_n(reset_n),
      .sel(sel),
      .data_in(data_in),
      .pc_write(pc_write),
      .pc_write_cond(pc_write_cond),
      .cond(cond),
      .exc_req(exc_req),
      .trap_ack(trap_ack),
      .mux_out(mux_out),
      .pc(pc),
      .epc(epc),
      .bad_value(bad_value),
      .cause(cause),
      .trap_valid(trap_valid)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] ref_mux(input int s);
      if (s == VS) return VEC;
      if (s < NS)  return lanes[s];
      return 32'h0;
   endfunction

   task automatic ref_reset();
      m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0;
      m_cause = 0;  m_trap = 1'b0;
   endtask

   task automatic ref_step();
      bit          w;
      int          s;
      logic [31:0] tgt;
      w   = pc_write | (pc_write_cond & cond);
      s   = int'(sel);
      tgt = ref_mux(s);
      if (m_trap) begin
         if (trap_ack) begin
            m_trap  = 1'b0;
            m_cause = 0;
         end
      end else if (exc_req) begin
         m_epc = m_pc; m_pc = VEC; m_cause = 1; m_trap = 1'b1;
      end else if (w && s >= NS) begin
         m_epc = m_pc; m_pc = VEC; m_bad = 32'h0;
         m_cause = 3; m_trap = 1'b1;
      end else if (w && tgt[1:0] != 2'b00) begin
         m_epc = m_pc; m_pc = VEC; m_bad = tgt;
         m_cause = 2; m_trap = 1'b1;
      end else if (w) begin
         m_pc = tgt;
      end
   endtask

   task automatic check_state(input string pfx);
      check({pfx, ".pc"}, pc, m_pc);
      check({pfx, ".epc"}, epc, m_epc);
      check({pfx, ".bad"}, bad_value, m_bad);
      check({pfx, ".cause"}, 32'(cause), 32'(m_cause));
      check({pfx, ".tv"}, 32'(trap_valid), 32'(m_trap));
   endtask

   task automatic step();
      @(negedge clk);
      check("mux", mux_out, ref_mux(int'(sel)));
      @(posedge clk);
      ref_step();
      #1;
      check_state("cyc");
   endtask

   task automatic drive(input int s, input bit pw, input bit pwc,
                        input bit c, input bit e, input bit a);
      sel = 3'(s); pc_write = pw; pc_write_cond = pwc;
      cond = c; exc_req = e; trap_ack = a;
   endtask

   initial begin
      for (int i = 0; i < NS; i++) lanes[i] = 32'h0;
      ref_reset();
      #2;
      check_state("rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      lanes[1] = 32'h40;
      drive(1, 1, 0, 0, 0, 0); step();
      check("load", pc, 32'h40);

      lanes[2] = 32'h100;
      drive(2, 0, 1, 0, 0, 0); step();
      check("br_nt", pc, 32'h40);
      drive(2, 0, 1, 1, 0, 0); step();
      check("br_t", pc, 32'h100);

      lanes[3] = 32'hDEAD_BEE2;
      drive(VS, 1, 0, 0, 0, 0); step();
      check("vec_pc", pc, VEC);
      check("vec_tv", 32'(trap_valid), 32'h0);

      drive(1, 1, 0, 0, 0, 0); step();
      lanes[1] = 32'h42; step();
      check("mis_cause", 32'(cause), 32'd2);
      check("mis_bad", bad_value, 32'h42);
      check("mis_epc", epc, 32'h40);
      lanes[1] = 32'h80; step(); step();
      check("trap_hold", pc, VEC);
      drive(1, 1, 0, 0, 0, 1); step();
      check("ack_tv", 32'(trap_valid), 32'h0);
      check("ack_pc", pc, VEC);
      drive(1, 1, 0, 0, 0, 0); step();
      check("post_ack", pc, 32'h80);

      lanes[1] = 32'h40;
      step();
      drive(7, 1, 0, 0, 0, 0); step();
      check("ill_cause", 32'(cause), 32'd3);
      check("ill_bad", bad_value, 32'h0);
      drive(6, 0, 0, 0, 0, 1); step();
      drive(1, 1, 0, 0, 0, 0); step();

      lanes[1] = 32'h42;
      drive(1, 1, 0, 0, 1, 0); step();
      check("pri_cause", 32'(cause), 32'd1);
      check("pri_epc", epc, 32'h40);
      drive(0, 0, 0, 0, 0, 1); step();

      drive(0, 0, 0, 0, 1, 0); step();
      check("pre_rst_tv", 32'(trap_valid), 32'h1);
      #1 reset_n = 1'b0;
      #1;
      ref_reset();
      check_state("midrst");
      reset_n = 1'b1;
      lanes[1] = 32'h40;
      drive(1, 1, 0, 0, 0, 0); step();
      check("rst_load", pc, 32'h40);

      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NS; i++) begin
            lanes[i] = $urandom;
            if ($urandom_range(0, 3) != 0) lanes[i][1:0] = 2'b00;
         end
         drive(int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) == 0));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_src_unit.md
# pc_src_unit

Parametrised next-PC source selector and program-counter register for the CPU datapath, with a built-in trap sequencer. It selects one of `NSRC` candidate targets. Candidates include PC+4, ALU result, jump target, EPC and other sources; one slot is hardwired to a constant exception vector. It loads the selected target into the PC on an unconditional or branch-conditional write. On an external exception, a misaligned target or an illegal selector, it diverts to the vector, captures EPC and cause, and holds a trap handshake until the control unit acknowledges.

## Interface
- `WIDTH`, 32: address/data width.
- `NSRC`, 6: number of selectable sources, 2..16.
- `SEL_W`, 3: selector width; must satisfy 2^SEL_W >= NSRC.
- `VEC_SLOT`, 3: source index replaced by the constant vector; the `data_in` lane at this index is ignored.
- `VEC_VALUE`, 32'h04C4B4B4: exception vector value.
- `RESET_PC`, 0: PC value after reset.
- `ALIGN_CHECK`, 1: 1 enables the word-alignment check on writes.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sel`  in  SEL_W  source selector.
- `data_in`  in  NSRC*WIDTH  flattened sources; lane i is bits [i*WIDTH +: WIDTH].
- `pc_write`  in  1  unconditional PC write.
- `pc_write_cond`  in  1  branch write, qualified by `cond`.
- `cond`  in  1  branch condition (ALU zero/compare).
- `exc_req`  in  1  external exception request, sampled per cycle.
- `trap_ack`  in  1  control unit acknowledges the trap.
- `mux_out`  out  WIDTH  combinational selected source.
- `pc`  out  WIDTH  PC register.
- `epc`  out  WIDTH  PC at trap entry.
- `bad_value`  out  WIDTH  offending target for cause 2 or 3.
- `cause`  out  2  0 none, 1 external, 2 misaligned, 3 illegal selector.
- `trap_valid`  out  1  high while in TRAP.

## Operation
- **Mux**
  - `mux_out` = `VEC_VALUE` when `sel`==`VEC_SLOT`.
  - `mux_out` = lane `sel` when `sel`<`NSRC`.
  - `mux_out` = 0 when `sel`>=`NSRC`.
- **Write enable:** `we` = `pc_write` | (`pc_write_cond` & `cond`).
- **FSM states:** RUN, TRAP.
- **RUN, priority order each cycle:**
  1. `exc_req`=1: pc<=VEC_VALUE, epc<=pc, cause<=1, go to TRAP. `we` is ignored.
  2. `we`=1 and `sel`>=`NSRC`: pc<=VEC_VALUE, epc<=pc, bad_value<=0, cause<=3, go to TRAP.
  3. `we`=1, `ALIGN_CHECK`=1 and `mux_out[1:0]`!=0: pc<=VEC_VALUE, epc<=pc, bad_value<=mux_out, cause<=2, go to TRAP.
  4. `we`=1 otherwise: pc<=mux_out, stay in RUN.
  5. Otherwise: pc holds.
- **TRAP**
  - `trap_valid`=1; pc, epc, bad_value and cause hold.
  - `we` and `exc_req` are ignored and not queued.
  - `trap_ack`=1: go to RUN next edge, cause<=0. epc and bad_value keep their values until the next trap.
  - A write presented in the ack cycle is ignored.
- `trap_ack` in RUN has no effect.
- Selecting `VEC_SLOT` with `we` is a normal write; it causes no trap.

## Timing
- **Reset** (asynchronous, `reset_n`=0):
  - pc=RESET_PC, epc=0, bad_value=0, cause=0, trap_valid=0, state RUN.
  - `reset_n` low in TRAP aborts the trap immediately.
- `mux_out` has zero latency from `sel` and `data_in`.
- The PC updates at the rising edge of the cycle with `we`=1; the new value is visible the following cycle.
- `trap_valid` rises the cycle after the trap event, together with pc=VEC_VALUE.
- `trap_valid` falls the cycle after the `trap_ack` edge.
- The earliest accepted write after a trap is the cycle after `trap_valid` falls.
- Trap entry costs one cycle plus the handshake wait; minimum round trip is 2 cycles (event, then ack).
- Writes in consecutive cycles are all accepted in RUN: back-to-back loads at one per cycle.

## Test plan
- **Reset and normal load:**
  - `reset_n` low → pc=0, trap_valid=0.
  - Release; sel=1, lane1=0x00000040, pc_write=1 for one cycle → pc=0x40 next cycle.
- **Branch qualification:**
  - pc_write_cond=1, cond=0, lane2=0x100 → pc unchanged.
  - cond=1 → pc=0x100.
  - sel=VEC_SLOT with write → pc=0x04C4B4B4, trap_valid stays 0.
- **Misaligned target:**
  - pc=0x40; sel=1, lane1=0x00000042, pc_write=1.
  - → pc=0x04C4B4B4, epc=0x40, bad_value=0x42, cause=2, trap_valid=1.
  - Writes held while in TRAP are ignored.
  - trap_ack → cause=0 and trap_valid=0 one cycle later.
- **Illegal selector and priority:**
  - NSRC=6, sel=7, pc_write=1 → cause=3, bad_value=0.
  - Separately, exc_req=1 with a misaligned write in the same cycle → cause=1, pc=VEC_VALUE, epc=old pc.
- **Reset mid-trap:**
  - Enter TRAP, then pulse reset_n low between edges.
  - → all outputs return to reset values immediately, state RUN.
  - A valid write on the first cycle after release loads normally.
